// File: rtl/trigger_receiver_pkg.sv
// Shared types and defaults for the trigger receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trigger_receiver_pkg;

  // Acquisition sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DECIDE   = 2'd1,
    ST_ACQUIRE  = 2'd2,
    ST_CLEARING = 2'd3
  } state_t;

  // Counter width and default timing parameters.
  localparam int CNT_WIDTH_DEF   = 20;
  localparam int TIMEOUT_DEF     = 256;
  localparam int CLEAR_TICKS_DEF = 4;

  // Internal timer widths sized to the legal parameter ranges
  // (TIMEOUT up to 65535, CLEAR_TICKS up to 255).
  localparam int TIMER_W = 16;
  localparam int CLR_W   = 8;

endpackage

// File: rtl/trigger_receiver_sync_edge_det.sv
// 2-FF synchroniser followed by a registered rising-edge detector.
// Latency: input edge before clock N gives a one-cycle rise pulse in cycle N+2.
// Backpressure: none; a level held high yields exactly one pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-stage synchroniser, one history flop, registered edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise   <= sync_q & ~prev_q;
    end
  end

endmodule

// File: rtl/trigger_receiver.sv
// Sequences one acquisition per HOLD edge: hold, TDC stop, ADC start, fast clear.
// Latency: trigger edge before clock N drives registered outputs at edge N+3.
// Backpressure: none; HOLD edges arriving while busy are counted as missed.
module trigger_receiver
  import trigger_receiver_pkg::*;
#(
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int CLEAR_TICKS = CLEAR_TICKS_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                 clk_50M,
  input  logic                 rst,
  input  logic                 HOLD,
  input  logic                 TSTOP,
  input  logic                 ACCEPT,
  input  logic                 CLEAR,
  input  logic                 adc_done,
  output logic                 hold_out,
  output logic                 tdc_stop,
  output logic                 adc_start,
  output logic                 fast_clear,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] event_cnt,
  output logic [CNT_WIDTH-1:0] timeout_cnt,
  output logic [CNT_WIDTH-1:0] missed_cnt
);

  // Final count values of the decision window and of the clear pulse.
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [CLR_W-1:0]   CLEAR_LAST   = CLR_W'(CLEAR_TICKS - 1);

  // Decoded one-cycle trigger events.
  logic hold_e;
  logic tstop_e;
  logic accept_e;
  logic clear_e;

  sync_edge_det u_hold (
    .clk  (clk_50M),
    .rst  (rst),
    .din  (HOLD),
    .rise (hold_e)
  );

  sync_edge_det u_tstop (
    .clk  (clk_50M),
    .rst  (rst),
    .din  (TSTOP),
    .rise (tstop_e)
  );

  sync_edge_det u_accept (
    .clk  (clk_50M),
    .rst  (rst),
    .din  (ACCEPT),
    .rise (accept_e)
  );

  sync_edge_det u_clear (
    .clk  (clk_50M),
    .rst  (rst),
    .din  (CLEAR),
    .rise (clear_e)
  );

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic                 tdc_sent_q, tdc_sent_d;
  logic                 tdc_stop_d;
  logic                 adc_start_d;
  logic                 event_inc;
  logic                 timeout_inc;
  logic                 missed_inc;

  // State register plus timers, TDC-issued flag and registered pulses.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      clr_cnt_q  <= '0;
      tdc_sent_q <= 1'b0;
      tdc_stop   <= 1'b0;
      adc_start  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      clr_cnt_q  <= clr_cnt_d;
      tdc_sent_q <= tdc_sent_d;
      tdc_stop   <= tdc_stop_d;
      adc_start  <= adc_start_d;
    end
  end

  // Next-state decode; CLEAR beats ACCEPT, which beats the timeout.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    clr_cnt_d   = clr_cnt_q;
    tdc_sent_d  = tdc_sent_q;
    tdc_stop_d  = 1'b0;
    adc_start_d = 1'b0;
    event_inc   = 1'b0;
    timeout_inc = 1'b0;
    missed_inc  = hold_e && (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (hold_e) begin
          state_d    = ST_DECIDE;
          timer_d    = '0;
          tdc_sent_d = 1'b0;
        end
      end

      ST_DECIDE: begin
        timer_d = timer_q + 16'd1;
        // Only the first TSTOP edge of an event reaches the TDC.
        if (tstop_e && !tdc_sent_q) begin
          tdc_stop_d = 1'b1;
          tdc_sent_d = 1'b1;
        end
        if (clear_e) begin
          state_d   = ST_CLEARING;
          clr_cnt_d = '0;
        end else if (accept_e) begin
          adc_start_d = 1'b1;
          state_d     = ST_ACQUIRE;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout_inc = 1'b1;
          state_d     = ST_CLEARING;
          clr_cnt_d   = '0;
        end
      end

      ST_ACQUIRE: begin
        // No timeout here: the ADC block always answers with adc_done.
        if (adc_done) begin
          event_inc = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_CLEARING: begin
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (clr_cnt_q == CLEAR_LAST) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Slow-control counters, wrapping modulo 2^CNT_WIDTH.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      event_cnt   <= '0;
      timeout_cnt <= '0;
      missed_cnt  <= '0;
    end else begin
      if (event_inc) begin
        event_cnt <= event_cnt + CNT_WIDTH'(1);
      end
      if (timeout_inc) begin
        timeout_cnt <= timeout_cnt + CNT_WIDTH'(1);
      end
      if (missed_inc) begin
        missed_cnt <= missed_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Level outputs decode straight from the state register.
  assign hold_out   = (state_q == ST_DECIDE) || (state_q == ST_ACQUIRE);
  assign fast_clear = (state_q == ST_CLEARING);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trigger_receiver.sv
`timescale 1ns/1ps
module tb_trigger_receiver;

  localparam int CW = 20;

  logic          clk_50M = 1'b0;
  logic          rst = 1'b1;
  logic          HOLD = 1'b0;
  logic          TSTOP = 1'b0;
  logic          ACCEPT = 1'b0;
  logic          CLEAR = 1'b0;
  logic          adc_done = 1'b0;
  logic          hold_out;
  logic          tdc_stop;
  logic          adc_start;
  logic          fast_clear;
  logic          busy;
  logic [CW-1:0] event_cnt;
  logic [CW-1:0] timeout_cnt;
  logic [CW-1:0] missed_cnt;

  trigger_receiver #(
    .TIMEOUT     (256),
    .CLEAR_TICKS (4),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk_50M     (clk_50M),
    .rst         (rst),
    .HOLD        (HOLD),
    .TSTOP       (TSTOP),
    .ACCEPT      (ACCEPT),
    .CLEAR       (CLEAR),
    .adc_done    (adc_done),
    .hold_out    (hold_out),
    .tdc_stop    (tdc_stop),
    .adc_start   (adc_start),
    .fast_clear  (fast_clear),
    .busy        (busy),
    .event_cnt   (event_cnt),
    .timeout_cnt (timeout_cnt),
    .missed_cnt  (missed_cnt)
  );

  always #10 clk_50M = ~clk_50M;

  int checks = 0;
  int errors = 0;

  // Bench model of the counters.
  int exp_ev = 0;
  int exp_to = 0;
  int exp_ms = 0;

  // Expected outcome of one busy period, pushed when the event is started.
  typedef struct {
    int tdc;
    int adc;
    int clr;
    int ev;
    int to;
    int ms;
  } rec_t;

  rec_t sb[$];
  rec_t got;
  int   mon_tdc = 0;
  int   mon_adc = 0;
  int   mon_clr = 0;
  logic prev_busy = 1'b0;

  task automatic step(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  // Steps until adc_start is seen; n = cycles taken.
  task automatic wait_adc_start(input int limit, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      step(1);
      n++;
      if (adc_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_fast_clear(input int limit, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      step(1);
      n++;
      if (fast_clear === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int limit, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (!ok && n < limit) begin
      step(1);
      n++;
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++;
    if ({hold_out, tdc_stop, adc_start, fast_clear, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=00000", {hold_out, tdc_stop, adc_start, fast_clear, busy});
    end
    checks++;
    if (event_cnt !== '0 || timeout_cnt !== '0 || missed_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0", event_cnt, timeout_cnt, missed_cnt);
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_accept();
    int n;
    bit ok;
    sb.push_back('{1, 1, 0, exp_ev + 1, exp_to, exp_ms});
    exp_ev++;
    HOLD = 1'b1;
    step(3);
    checks++;
    if (hold_out !== 1'b0) begin
      errors++;
      $display("FAIL accept_hold_early got=%b want=0", hold_out);
    end
    step(1);
    checks++;
    if (hold_out !== 1'b1) begin
      errors++;
      $display("FAIL accept_hold_rise got=%b want=1", hold_out);
    end
    step(92);
    TSTOP = 1'b1;
    step(32);
    ACCEPT = 1'b1;
    wait_adc_start(20, n, ok);
    checks++;
    if (!ok || n != 4) begin
      errors++;
      $display("FAIL accept_adc_start_latency got=%0d found=%0d want=4", n, ok);
    end
    step(10);
    adc_done = 1'b1;
    checks++;
    if (hold_out !== 1'b1) begin
      errors++;
      $display("FAIL accept_hold_before_done got=%b want=1", hold_out);
    end
    step(1);
    adc_done = 1'b0;
    checks++;
    if (hold_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL accept_hold_release got=%b%b want=00", hold_out, busy);
    end
    checks++;
    if (event_cnt !== CW'(exp_ev)) begin
      errors++;
      $display("FAIL accept_event_cnt got=%0d want=%0d", event_cnt, exp_ev);
    end
    HOLD = 1'b0;
    TSTOP = 1'b0;
    ACCEPT = 1'b0;
    step(4);
  endtask

  task automatic test_reject();
    int n;
    int len;
    bit ok;
    sb.push_back('{0, 0, 4, exp_ev, exp_to, exp_ms});
    HOLD = 1'b1;
    step(50);
    CLEAR = 1'b1;
    wait_fast_clear(20, n, ok);
    checks++;
    if (!ok || n != 4) begin
      errors++;
      $display("FAIL reject_clear_latency got=%0d found=%0d want=4", n, ok);
    end
    checks++;
    if (hold_out !== 1'b0) begin
      errors++;
      $display("FAIL reject_hold_low got=%b want=0", hold_out);
    end
    len = 0;
    while (fast_clear === 1'b1 && len < 20) begin
      len++;
      step(1);
    end
    checks++;
    if (len != 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_clear_width got=%0d busy=%b want=4 busy=0", len, busy);
    end
    checks++;
    if (event_cnt !== CW'(exp_ev)) begin
      errors++;
      $display("FAIL reject_event_cnt got=%0d want=%0d", event_cnt, exp_ev);
    end
    HOLD = 1'b0;
    CLEAR = 1'b0;
    step(4);
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    sb.push_back('{0, 0, 4, exp_ev, exp_to + 1, exp_ms});
    exp_to++;
    HOLD = 1'b1;
    step(4);
    checks++;
    if (hold_out !== 1'b1) begin
      errors++;
      $display("FAIL timeout_decide_entry got=%b want=1", hold_out);
    end
    wait_fast_clear(300, n, ok);
    checks++;
    if (!ok || n != 256) begin
      errors++;
      $display("FAIL timeout_window got=%0d found=%0d want=256", n, ok);
    end
    checks++;
    if (timeout_cnt !== CW'(exp_to)) begin
      errors++;
      $display("FAIL timeout_cnt got=%0d want=%0d", timeout_cnt, exp_to);
    end
    wait_idle(10, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_return_idle got=busy want=idle");
    end
    HOLD = 1'b0;
    step(4);
  endtask

  task automatic test_simultaneous();
    int n;
    bit ok;
    bit adc_seen;
    bit fc_seen;
    sb.push_back('{0, 0, 4, exp_ev, exp_to, exp_ms});
    HOLD = 1'b1;
    step(20);
    ACCEPT = 1'b1;
    CLEAR = 1'b1;
    adc_seen = 1'b0;
    fc_seen = 1'b0;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 30) begin
      step(1);
      n++;
      if (adc_start === 1'b1) adc_seen = 1'b1;
      if (fast_clear === 1'b1) fc_seen = 1'b1;
      if (busy === 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok || !fc_seen || adc_seen) begin
      errors++;
      $display("FAIL simul_clear_wins idle=%0d fc=%0d adc=%0d want=1/1/0", ok, fc_seen, adc_seen);
    end
    checks++;
    if (event_cnt !== CW'(exp_ev)) begin
      errors++;
      $display("FAIL simul_event_cnt got=%0d want=%0d", event_cnt, exp_ev);
    end
    HOLD = 1'b0;
    ACCEPT = 1'b0;
    CLEAR = 1'b0;
    step(4);
  endtask

  task automatic test_missed_tstop();
    int n;
    bit ok;
    sb.push_back('{1, 1, 0, exp_ev + 1, exp_to, exp_ms + 2});
    exp_ev++;
    exp_ms += 2;
    HOLD = 1'b1;
    step(10);
    for (int i = 0; i < 3; i++) begin
      TSTOP = 1'b1;
      step(3);
      TSTOP = 1'b0;
      step(3);
    end
    step(2);
    ACCEPT = 1'b1;
    wait_adc_start(20, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL missed_adc_start got=none want=pulse");
    end
    for (int i = 0; i < 2; i++) begin
      HOLD = 1'b0;
      step(3);
      HOLD = 1'b1;
      step(3);
    end
    step(3);
    checks++;
    if (missed_cnt !== CW'(exp_ms)) begin
      errors++;
      $display("FAIL missed_cnt got=%0d want=%0d", missed_cnt, exp_ms);
    end
    checks++;
    if (hold_out !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL missed_still_acquire got=%b%b want=11", hold_out, busy);
    end
    adc_done = 1'b1;
    step(1);
    adc_done = 1'b0;
    checks++;
    if (event_cnt !== CW'(exp_ev)) begin
      errors++;
      $display("FAIL missed_event_cnt got=%0d want=%0d", event_cnt, exp_ev);
    end
    HOLD = 1'b0;
    ACCEPT = 1'b0;
    step(4);
  endtask

  task automatic test_adc_done_idle();
    adc_done = 1'b1;
    step(1);
    adc_done = 1'b0;
    step(2);
    checks++;
    if (event_cnt !== CW'(exp_ev) || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_adc_done_dropped got=%0d busy=%b want=%0d busy=0", event_cnt, busy, exp_ev);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    sb.push_back('{0, 1, 0, exp_ev + 1, exp_to, exp_ms});
    sb.push_back('{0, 0, 4, exp_ev + 1, exp_to, exp_ms});
    exp_ev++;
    HOLD = 1'b1;
    step(6);
    ACCEPT = 1'b1;
    wait_adc_start(20, n, ok);
    HOLD = 1'b0;
    ACCEPT = 1'b0;
    step(4);
    // Time the new HOLD edge to decode in the first IDLE cycle.
    HOLD = 1'b1;
    step(2);
    adc_done = 1'b1;
    step(1);
    adc_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap got=%b want=0", busy);
    end
    step(1);
    checks++;
    if (busy !== 1'b1 || hold_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart got=%b%b want=11", busy, hold_out);
    end
    checks++;
    if (missed_cnt !== CW'(exp_ms)) begin
      errors++;
      $display("FAIL b2b_missed_cnt got=%0d want=%0d", missed_cnt, exp_ms);
    end
    CLEAR = 1'b1;
    wait_idle(20, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_second_end got=busy want=idle");
    end
    CLEAR = 1'b0;
    HOLD = 1'b0;
    step(4);
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    sb.push_back('{0, 1, 0, 0, 0, 0});
    HOLD = 1'b1;
    step(6);
    ACCEPT = 1'b1;
    wait_adc_start(20, n, ok);
    HOLD = 1'b0;
    ACCEPT = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_ev = 0;
    exp_to = 0;
    exp_ms = 0;
    checks++;
    if ({hold_out, tdc_stop, adc_start, fast_clear, busy} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_outputs got=%b want=00000", {hold_out, tdc_stop, adc_start, fast_clear, busy});
    end
    checks++;
    if (event_cnt !== '0 || timeout_cnt !== '0 || missed_cnt !== '0) begin
      errors++;
      $display("FAIL midrst_counters got=%0d/%0d/%0d want=0/0/0", event_cnt, timeout_cnt, missed_cnt);
    end
    step(2);
    sb.push_back('{0, 1, 0, 1, 0, 0});
    exp_ev = 1;
    HOLD = 1'b1;
    step(4);
    checks++;
    if (hold_out !== 1'b1) begin
      errors++;
      $display("FAIL midrst_new_hold got=%b want=1", hold_out);
    end
    ACCEPT = 1'b1;
    wait_adc_start(20, n, ok);
    step(3);
    adc_done = 1'b1;
    step(1);
    adc_done = 1'b0;
    checks++;
    if (event_cnt !== CW'(1) || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_new_event got=%0d busy=%b want=1 busy=0", event_cnt, busy);
    end
    HOLD = 1'b0;
    ACCEPT = 1'b0;
    step(4);
  endtask

  initial begin
    fork
      // Scoreboard monitor: tallies pulses per busy period, compares at its end.
      forever begin
        @(negedge clk_50M);
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
          mon_tdc = 0;
          mon_adc = 0;
          mon_clr = 0;
        end
        if (busy === 1'b1) begin
          mon_tdc += int'(tdc_stop);
          mon_adc += int'(adc_start);
          mon_clr += int'(fast_clear);
        end
        if (busy === 1'b0 && prev_busy === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow got=event want=none");
          end else begin
            got = sb.pop_front();
            checks++;
            if (mon_tdc != got.tdc) begin
              errors++;
              $display("FAIL sb_tdc_pulses got=%0d want=%0d", mon_tdc, got.tdc);
            end
            checks++;
            if (mon_adc != got.adc) begin
              errors++;
              $display("FAIL sb_adc_pulses got=%0d want=%0d", mon_adc, got.adc);
            end
            checks++;
            if (mon_clr != got.clr) begin
              errors++;
              $display("FAIL sb_clear_cycles got=%0d want=%0d", mon_clr, got.clr);
            end
            checks++;
            if (event_cnt !== CW'(got.ev) || timeout_cnt !== CW'(got.to) || missed_cnt !== CW'(got.ms)) begin
              errors++;
              $display("FAIL sb_counters got=%0d/%0d/%0d want=%0d/%0d/%0d",
                       event_cnt, timeout_cnt, missed_cnt, got.ev, got.to, got.ms);
            end
          end
        end
        prev_busy = busy;
      end
    join_none

    test_reset();
    test_accept();
    test_reject();
    test_timeout();
    test_simultaneous();
    test_missed_tstop();
    test_adc_done_idle();
    test_back_to_back();
    test_reset_mid();
    step(5);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
